tdm_demux: RTL and testbench



---
 rtl/tdm_demux_if.sv | 26 ++
 rtl/tdm_demux.sv | 106 ++++++++++
 tb/tb_tdm_demux.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/tdm_demux_if.sv
// Bundles the muxed input beat and the reconstructed-frame outputs of tdm_demux.
interface tdm_demux_if #(
  parameter int unsigned WIDTH    = 1,
  parameter int unsigned CHANNELS = 2
);
  localparam int unsigned SLOT_BITS = $clog2(CHANNELS);

  logic [WIDTH-1:0]          din;
  logic                      in_valid;
  logic                      sync;
  logic [CHANNELS*WIDTH-1:0] frame_data;
  logic                      frame_valid;
  logic                      sync_err;
  logic                      locked;
  logic [SLOT_BITS-1:0]      slot;

  modport master (
    output din, in_valid, sync,
    input  frame_data, frame_valid, sync_err, locked, slot
  );

  modport slave (
    input  din, in_valid, sync,
    output frame_data, frame_valid, sync_err, locked, slot
  );
endinterface

// File: rtl/tdm_demux.sv
// Splits a sync-framed time-multiplexed stream back into per-channel samples,
// publishing each complete frame atomically with a one-cycle valid pulse.
module tdm_demux #(
  parameter int unsigned WIDTH    = 1,
  parameter int unsigned CHANNELS = 2
) (
  input  logic       clk,
  input  logic       reset,
  tdm_demux_if.slave bus
);
  localparam int unsigned          SLOT_BITS = $clog2(CHANNELS);
  localparam logic [SLOT_BITS-1:0] LAST_SLOT = SLOT_BITS'(CHANNELS - 1);

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic [CHANNELS-1:0][WIDTH-1:0] shadow_q, shadow_d, shadow_wr;
  logic [CHANNELS*WIDTH-1:0]      frame_data_q, frame_data_d;
  logic                           frame_valid_q, frame_valid_d;
  logic                           sync_err_q, sync_err_d;
  logic                           locked_q, locked_d;
  logic [SLOT_BITS-1:0]           slot_q, slot_d;

  logic beat_sync, beat_missing, beat_data;

  // Classify the incoming beat; non-sync beats only matter while locked.
  always_comb begin
    beat_sync    = bus.in_valid && bus.sync;
    beat_missing = bus.in_valid && !bus.sync && (state_q == RUN) && (slot_q == '0);
    beat_data    = bus.in_valid && !bus.sync && (state_q == RUN) && (slot_q != '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= HUNT;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      HUNT: if (beat_sync)    state_d = RUN;
      RUN:  if (beat_missing) state_d = HUNT;
      default:                state_d = HUNT;
    endcase
  end

  always_comb begin
    shadow_wr     = shadow_q;
    shadow_d      = shadow_q;
    frame_data_d  = frame_data_q;
    frame_valid_d = 1'b0;
    sync_err_d    = 1'b0;
    slot_d        = slot_q;
    locked_d      = (state_d == RUN);

    if (beat_sync) begin
      // A sync beat always restarts the frame; mid-frame it also flags an error.
      shadow_d[0] = bus.din;
      slot_d      = SLOT_BITS'(1);
      sync_err_d  = (state_q == RUN) && (slot_q != '0);
    end else if (beat_missing) begin
      sync_err_d = 1'b1;
      slot_d     = '0;
    end else if (beat_data) begin
      for (int unsigned k = 1; k < CHANNELS; k++) begin
        if (slot_q == SLOT_BITS'(k)) shadow_wr[k] = bus.din;
      end
      shadow_d = shadow_wr;
      if (slot_q == LAST_SLOT) begin
        frame_data_d  = shadow_wr;
        frame_valid_d = 1'b1;
        slot_d        = '0;
      end else begin
        slot_d = slot_q + SLOT_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_q      <= '0;
      frame_data_q  <= '0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
      locked_q      <= 1'b0;
      slot_q        <= '0;
    end else begin
      shadow_q      <= shadow_d;
      frame_data_q  <= frame_data_d;
      frame_valid_q <= frame_valid_d;
      sync_err_q    <= sync_err_d;
      locked_q      <= locked_d;
      slot_q        <= slot_d;
    end
  end

  assign bus.frame_data  = frame_data_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.sync_err    = sync_err_q;
  assign bus.locked      = locked_q;
  assign bus.slot        = slot_q;
endmodule

// File: tb/tb_tdm_demux.sv
// Directed bench for tdm_demux: a 2x1-bit and a 4x4-bit instance share clk/reset.
module tb_tdm_demux;
  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  tdm_demux_if #(.WIDTH(1), .CHANNELS(2)) if2 ();
  tdm_demux_if #(.WIDTH(4), .CHANNELS(4)) if4 ();

  tdm_demux #(.WIDTH(1), .CHANNELS(2)) u_d2 (.clk(clk), .reset(reset), .bus(if2));
  tdm_demux #(.WIDTH(4), .CHANNELS(4)) u_d4 (.clk(clk), .reset(reset), .bus(if4));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; the beat is taken on the next posedge and we return at the following negedge.
  task automatic beat2(input logic s, input logic d);
    if2.in_valid = 1'b1; if2.sync = s; if2.din = d;
    @(negedge clk);
    if2.in_valid = 1'b0; if2.sync = 1'b0;
  endtask

  task automatic beat4(input logic s, input logic [3:0] d);
    if4.in_valid = 1'b1; if4.sync = s; if4.din = d;
    @(negedge clk);
    if4.in_valid = 1'b0; if4.sync = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    if2.in_valid = 1'b0; if2.sync = 1'b0; if2.din = '0;
    if4.in_valid = 1'b0; if4.sync = 1'b0; if4.din = '0;
    idle(2);
    check("rst_d2_data",   32'(if2.frame_data),  32'h0);
    check("rst_d2_valid",  32'(if2.frame_valid), 32'h0);
    check("rst_d2_err",    32'(if2.sync_err),    32'h0);
    check("rst_d2_locked", 32'(if2.locked),      32'h0);
    check("rst_d2_slot",   32'(if2.slot),        32'h0);
    check("rst_d4_data",   32'(if4.frame_data),  32'h0);
    check("rst_d4_slot",   32'(if4.slot),        32'h0);
    reset = 1'b0;
    idle(1);

    // Basic frame on the 2-channel instance
    beat2(1'b1, 1'b0);
    check("t1_valid_early", 32'(if2.frame_valid), 32'h0);
    check("t1_locked",      32'(if2.locked),      32'h1);
    check("t1_slot1",       32'(if2.slot),        32'h1);
    beat2(1'b0, 1'b1);
    check("t1_data",   32'(if2.frame_data),  32'h2);
    check("t1_valid",  32'(if2.frame_valid), 32'h1);
    check("t1_slot0",  32'(if2.slot),        32'h0);
    check("t1_noerr",  32'(if2.sync_err),    32'h0);
    idle(1);
    check("t1_valid_drop", 32'(if2.frame_valid), 32'h0);

    // Missing sync at slot 0 drops lock but keeps the last frame
    beat2(1'b0, 1'b1);
    check("ms_err",    32'(if2.sync_err),   32'h1);
    check("ms_locked", 32'(if2.locked),     32'h0);
    check("ms_slot",   32'(if2.slot),       32'h0);
    check("ms_data",   32'(if2.frame_data), 32'h2);
    idle(1);
    check("ms_err_drop", 32'(if2.sync_err), 32'h0);

    // Hunting: non-sync beats ignored silently
    beat2(1'b0, 1'b1);
    check("hunt_err1",  32'(if2.sync_err), 32'h0);
    beat2(1'b0, 1'b1);
    check("hunt_err2",  32'(if2.sync_err), 32'h0);
    check("hunt_lock0", 32'(if2.locked),   32'h0);
    beat2(1'b1, 1'b1);
    check("hunt_lock1", 32'(if2.locked),   32'h1);
    beat2(1'b0, 1'b0);
    check("hunt_data",  32'(if2.frame_data),  32'h1);
    check("hunt_valid", 32'(if2.frame_valid), 32'h1);

    // Gap of 5 idle cycles mid-frame
    beat2(1'b1, 1'b0);
    idle(5);
    check("gap_slot",  32'(if2.slot),        32'h1);
    check("gap_valid", 32'(if2.frame_valid), 32'h0);
    beat2(1'b0, 1'b1);
    check("gap_data",   32'(if2.frame_data),  32'h2);
    check("gap_pulse",  32'(if2.frame_valid), 32'h1);
    idle(1);
    check("gap_pulse_drop", 32'(if2.frame_valid), 32'h0);

    // Early sync on the 4-channel instance
    beat4(1'b1, 4'h7);
    beat4(1'b0, 4'h9);
    check("es_slot2", 32'(if4.slot), 32'h2);
    beat4(1'b1, 4'h2);
    check("es_err",    32'(if4.sync_err),    32'h1);
    check("es_novalid",32'(if4.frame_valid), 32'h0);
    check("es_slot1",  32'(if4.slot),        32'h1);
    check("es_locked", 32'(if4.locked),      32'h1);
    beat4(1'b0, 4'h3);
    check("es_err_drop", 32'(if4.sync_err), 32'h0);
    beat4(1'b0, 4'h4);
    check("es_slot3", 32'(if4.slot), 32'h3);
    beat4(1'b0, 4'h5);
    check("es_data",  32'(if4.frame_data),  32'h5432);
    check("es_valid", 32'(if4.frame_valid), 32'h1);

    // Asynchronous reset between edges mid-frame
    beat4(1'b1, 4'h6);
    beat4(1'b0, 4'h7);
    #2 reset = 1'b1;
    #1;
    check("ar_data",   32'(if4.frame_data),  32'h0);
    check("ar_locked", 32'(if4.locked),      32'h0);
    check("ar_slot",   32'(if4.slot),        32'h0);
    check("ar_valid",  32'(if4.frame_valid), 32'h0);
    check("ar_err",    32'(if4.sync_err),    32'h0);
    check("ar_d2data", 32'(if2.frame_data),  32'h0);
    @(negedge clk);
    reset = 1'b0;
    idle(1);
    beat4(1'b1, 4'h1);
    beat4(1'b0, 4'h2);
    beat4(1'b0, 4'h3);
    check("ar_midvalid", 32'(if4.frame_valid), 32'h0);
    beat4(1'b0, 4'h4);
    check("ar_fdata",  32'(if4.frame_data),  32'h4321);
    check("ar_fvalid", 32'(if4.frame_valid), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
